// File: rtl/mp_add_seq.sv
// mp_add_seq -- bit-serial-by-chunk multi-precision adder/subtractor.
//
// One N-bit chunk is added per clock, least significant chunk first, through
// a single N-bit adder. The inter-chunk carry lives in a register, so a
// W = N*K bit operation takes K cycles from accept to result.
//
// Ports
//   clk      : clock, rising edge
//   rstn     : asynchronous active-low reset
//   s_valid  : operands valid (sampled only while s_ready = 1)
//   s_ready  : block idle and able to accept operands
//   a, b     : W-bit operands
//   sub      : 1 = a - b, 0 = a + b
//   m_valid  : result valid, held until m_ready
//   m_ready  : downstream accepts result
//   sum      : W-bit result (mod 2^W)
//   c_out    : carry out of bit W-1 (for subtraction 1 = no borrow)
//   ovf      : signed overflow
//   zero     : sum == 0

module n_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  logic [N:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
  assign s    = full[N-1:0];
  assign co   = full[N];

endmodule

module mp_add_seq #(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [N*K-1:0]   a,
  input  logic [N*K-1:0]   b,
  input  logic             sub,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [N*K-1:0]   sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int W  = N * K;
  localparam int IW = $clog2(K);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            carry;
  logic [IW-1:0]   idx;

  logic [N-1:0]    a_ch;
  logic [N-1:0]    b_ch;
  logic [N-1:0]    s_ch;
  logic            co;
  logic            c_msb;
  logic            low_zero;
  logic            last;

  assign a_ch = a_q[idx*N +: N];
  assign b_ch = b_q[idx*N +: N];

  n_adder #(.N(N)) u_add (
    .a  (a_ch),
    .b  (b_ch),
    .ci (carry),
    .s  (s_ch),
    .co (co)
  );

  // Carry into the top bit of the chunk, recovered from its sum bit.
  assign c_msb    = s_ch[N-1] ^ a_ch[N-1] ^ b_ch[N-1];
  // Lower chunks are already final when the top chunk is being computed.
  assign low_zero = ~|sum[W-N-1:0];
  assign last     = (idx == IW'(K - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      c_out   <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // s_ready comes up on the first edge after reset release.
          if (s_valid && s_ready) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry   <= sub;
            idx     <= '0;
            s_ready <= 1'b0;
            state   <= RUN;
          end else begin
            s_ready <= 1'b1;
          end
        end

        RUN: begin
          sum[idx*N +: N] <= s_ch;
          carry           <= co;
          if (last) begin
            c_out   <= co;
            ovf     <= c_msb ^ co;
            zero    <= low_zero & ~|s_ch;
            m_valid <= 1'b1;
            state   <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            state   <= IDLE;
          end
        end

        default: begin
          m_valid <= 1'b0;
          s_ready <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
